// File: rtl/residual_add_nch.sv
// Residual add over CH fp32 channels: shortcut FIFO, 2-stage add/sub pipeline, frame marking.
// Define RESIDUAL_ADD_RELU_EN to clamp negative results (including -0.0) to +0.0.
module residual_add_nch #(
   parameter int CH         = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int FRAME_LEN  = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          sub_mode,
   input  logic                          input_valid_short_cut,
   input  logic [CH*32-1:0]              d_in_short_cut,
   input  logic                          input_valid_layer,
   input  logic [CH*32-1:0]              d_in_layer,
   output logic [CH*32-1:0]              d_out,
   output logic                          output_valid,
   output logic                          o_sof,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          err_overflow,
   output logic                          err_underflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [AW-1:0] PTR_ONE   = 1;
   localparam logic [AW:0]   LVL_ONE   = 1;
   localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE   = 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_LEN - 1);

   // IEEE-754 single add/sub, round to nearest even, subnormals kept, NaN canonical.
   // NOTE: functions and always_comb use blocking '='; only clocked state uses '<='.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
      logic        sa, sb, sl, ss;
      logic [7:0]  ea, eb;
      logic [9:0]  el, es, e, d;
      logic [23:0] ml, ms;
      logic [53:0] sh;
      logic [26:0] lm, sm;
      logic [27:0] s;
      logic [24:0] m;
      logic        rnd;
      sa = a[31];
      sb = b[31] ^ sub;
      ea = a[30:23];
      eb = b[30:23];
      if ((ea == 8'hFF && a[22:0] != 23'h0) || (eb == 8'hFF && b[22:0] != 23'h0))
         return 32'h7FC0_0000;
      if (ea == 8'hFF && eb == 8'hFF)
         return (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC0_0000;
      if (ea == 8'hFF) return {sa, 8'hFF, 23'h0};
      if (eb == 8'hFF) return {sb, 8'hFF, 23'h0};
      // Order operands by magnitude so the subtraction below never goes negative.
      if (b[30:0] > a[30:0]) begin
         sl = sb; el = {2'b00, (eb == 8'd0) ? 8'd1 : eb}; ml = {|eb, b[22:0]};
         ss = sa; es = {2'b00, (ea == 8'd0) ? 8'd1 : ea}; ms = {|ea, a[22:0]};
      end else begin
         sl = sa; el = {2'b00, (ea == 8'd0) ? 8'd1 : ea}; ml = {|ea, a[22:0]};
         ss = sb; es = {2'b00, (eb == 8'd0) ? 8'd1 : eb}; ms = {|eb, b[22:0]};
      end
      d = el - es;
      if (d > 10'd27) d = 10'd27;
      sh = {ms, 3'b000, 27'h0} >> d;
      sm = sh[53:27];
      sm[0] = sm[0] | (|sh[26:0]);
      lm = {ml, 3'b000};
      if (sl == ss) s = {1'b0, lm} + {1'b0, sm};
      else          s = {1'b0, lm} - {1'b0, sm};
      if (s == 28'h0) return {sl & ss, 31'h0};
      e = el;
      if (s[27]) begin
         s = {1'b0, s[27:2], s[1] | s[0]};
         e = e + 10'd1;
      end
      for (int i = 0; i < 26; i++) begin
         if (!s[26] && e > 10'd1) begin
            s = s << 1;
            e = e - 10'd1;
         end
      end
      rnd = s[2] & (s[1] | s[0] | s[3]);
      m = {1'b0, s[26:3]} + {24'h0, rnd};
      if (m[24]) begin
         m = m >> 1;
         e = e + 10'd1;
      end
      if (e >= 10'd255) return {sl, 8'hFF, 23'h0};
      return {sl, m[23] ? e[7:0] : 8'h00, m[22:0]};
   endfunction

   // Shortcut FIFO, first-word-fall-through
   logic [CH*32-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             full, empty, push, pop;
   logic [CH*32-1:0] head;

   assign full  = (fifo_level == LVL_FULL);
   assign empty = (fifo_level == '0);
   assign pop   = input_valid_layer & ~empty;
   assign push  = input_valid_short_cut & (~full | pop);
   assign head  = empty ? '0 : mem[rd_ptr];

   // NOTE: FIFO storage carries no reset; validity comes from the reset pointers and level.
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr] <= d_in_short_cut;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_level    <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else if (clr) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_level    <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_ONE;
            2'b01:   fifo_level <= fifo_level - LVL_ONE;
            default: fifo_level <= fifo_level;
         endcase
         if (input_valid_short_cut && full && !pop) err_overflow  <= 1'b1;
         if (input_valid_layer && empty)            err_underflow <= 1'b1;
      end
   end

   // Stage 0: operand capture
   logic             valid0, sub0;
   logic [CH*32-1:0] layer0, short0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid0 <= 1'b0;
         sub0   <= 1'b0;
         layer0 <= '0;
         short0 <= '0;
      end else if (clr) begin
         valid0 <= 1'b0;
      end else begin
         valid0 <= input_valid_layer;
         if (input_valid_layer) begin
            sub0   <= sub_mode;
            layer0 <= d_in_layer;
            short0 <= head;
         end
      end
   end

   logic [CH*32-1:0] sum_vec;

   always_comb begin
      sum_vec = '0;
      for (int c = 0; c < CH; c++) begin
         sum_vec[c*32 +: 32] = fp_add(layer0[c*32 +: 32], short0[c*32 +: 32], sub0);
`ifdef RESIDUAL_ADD_RELU_EN
         if (sum_vec[c*32 + 31]) sum_vec[c*32 +: 32] = 32'h0;
`endif
      end
   end

   // Stage 1: result register and frame position
   logic [CW-1:0] frame_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_out        <= '0;
         output_valid <= 1'b0;
         frame_cnt    <= '0;
      end else if (clr) begin
         output_valid <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         output_valid <= valid0;
         if (valid0) d_out <= sum_vec;
         if (output_valid) frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CNT_ONE;
      end
   end

   assign o_sof = output_valid & (frame_cnt == '0);

endmodule
